// File: rtl/sync_lutram_fifo_1w_2r.sv
// Synchronous FIFO on distributed RAM with one write port and two asynchronous read
// ports exposing the head entry and the one behind it, popping one or two per cycle.
module sync_lutram_fifo_1w_2r #(
    parameter int DWIDTH = 1,
    parameter int DEPTH  = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DWIDTH-1:0]          din,
    input  logic                       we,
    input  logic [1:0]                 re,
    output logic                       empty,
    output logic                       full,
    output logic                       two_avail,
    output logic [$clog2(DEPTH):0]     count,
    output logic [DWIDTH-1:0]          dout0,
    output logic [DWIDTH-1:0]          dout1
);
    localparam int AW = $clog2(DEPTH);

    generate
        if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("sync_lutram_fifo_1w_2r: DEPTH must be a power of two and >= 4");
        end
    endgenerate

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]     head_q, head_d;
    logic [AW-1:0]     tail_q, tail_d;
    logic [AW:0]       count_q, count_d;

    logic        wr_ok;
    logic        pop1_ok;
    logic        pop2_ok;
    logic [AW:0] pop_n;

    // Flags look only at the registered occupancy, so no input reaches them.
    assign empty     = (count_q == '0);
    assign full      = (count_q == (AW+1)'(DEPTH));
    assign two_avail = (count_q >= (AW+1)'(2));
    assign count     = count_q;

    assign wr_ok   = we && !full;
    assign pop1_ok = (re == 2'b01) && !empty;
    assign pop2_ok = (re == 2'b11) && two_avail;

    always_comb begin
        pop_n   = '0;
        head_d  = head_q;
        tail_d  = tail_q;
        if (pop1_ok) begin
            pop_n  = (AW+1)'(1);
            head_d = head_q + AW'(1);
        end else if (pop2_ok) begin
            pop_n  = (AW+1)'(2);
            head_d = head_q + AW'(2);
        end
        if (wr_ok) begin
            tail_d = tail_q + AW'(1);
        end
        count_d = count_q + (AW+1)'(wr_ok) - pop_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is never cleared; reset only rewinds the pointers.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem_q[tail_q] <= din;
        end
    end

    logic [DWIDTH-1:0] rd_data [2];
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            logic [AW-1:0] rd_ptr;
            assign rd_ptr      = head_q + AW'(gi);
            assign rd_data[gi] = mem_q[rd_ptr];
        end
    endgenerate

    assign dout0 = rd_data[0];
    assign dout1 = rd_data[1];

`ifndef SYNTHESIS
    a_wr_full: assert property (@(posedge clk) disable iff (rst) !(we && full))
        else $warning("write while full dropped");
    a_pop1_empty: assert property (@(posedge clk) disable iff (rst) !((re == 2'b01) && empty))
        else $warning("pop-one while empty rejected");
    a_pop2_short: assert property (@(posedge clk) disable iff (rst) !((re == 2'b11) && !two_avail))
        else $warning("pop-two with fewer than two entries rejected");
    a_re_illegal: assert property (@(posedge clk) disable iff (rst) re != 2'b10)
        else $warning("illegal re encoding 2'b10");
`endif
endmodule

// File: doc/sync_lutram_fifo_1w_2r.md
SYNC_LUTRAM_FIFO_1W_2R -- requirements
Module: sync_lutram_fifo_1w_2r

Interface
REQ-001 SHALL have parameter DWIDTH, default 1, entry width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, capacity in entries; power of two, >=4.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port din  input  DWIDTH  enqueue data.
REQ-006 SHALL have port we  input  1  enqueue request, one entry per cycle.
REQ-007 SHALL have port re  input  2  dequeue request: 2'b00 none, 2'b01 pop one, 2'b11 pop two; 2'b10 illegal.
REQ-008 SHALL have port empty  output  1  occupancy == 0.
REQ-009 SHALL have port full  output  1  occupancy == DEPTH.
REQ-010 SHALL have port two_avail  output  1  occupancy >= 2.
REQ-011 SHALL have port count  output  log2(DEPTH)+1  current occupancy.
REQ-012 SHALL have port dout0  output  DWIDTH  oldest entry (head).
REQ-013 SHALL have port dout1  output  DWIDTH  second-oldest entry (head+1).

Function
REQ-014 Storage SHALL be DEPTH x DWIDTH LUTRAM: one write port, two asynchronous read ports (head, head+1).
REQ-015 Head and tail pointers SHALL be log2(DEPTH) bits, wrap modulo DEPTH with no special casing.
REQ-016 Occupancy SHALL be held in a registered counter of log2(DEPTH)+1 bits; full capacity is DEPTH entries (no sacrificed slot).
REQ-017 empty, full, two_avail, count SHALL derive combinationally from the registered counter only; no input-to-flag paths.
REQ-018 dout0 = ram[head], dout1 = ram[head+1 mod DEPTH], combinational from registered head; no output register.
REQ-019 dout0 SHALL be meaningful only when !empty; dout1 only when two_avail; otherwise contents undefined.
REQ-020 Write accepted iff we && !full at the clock edge: ram[tail] <= din, tail += 1.
REQ-021 Pop-one accepted iff re==2'b01 && !empty: head += 1.
REQ-022 Pop-two accepted iff re==2'b11 && two_avail: head += 2.
REQ-023 Acceptance SHALL use occupancy at cycle start; same-cycle write SHALL NOT enable a read (no bypass), same-cycle read SHALL NOT free space for a write.
REQ-024 Next count = count + (write accepted) - (entries popped); simultaneous accepted write and pop SHALL update both pointers in one cycle.
REQ-025 Rejected requests (write when full, pop exceeding occupancy, re==2'b10) SHALL leave pointers, count and RAM unchanged.
REQ-026 Data written at edge N SHALL be readable on dout0/dout1 after edge N (one-cycle write-to-read latency).
REQ-027 Simulation-only assertions SHALL flag (disabled during rst): we&&full, re==2'b01&&empty, re==2'b11&&!two_avail, re==2'b10.
REQ-028 Elaboration-time check SHALL error if DEPTH is not a power of two.

Reset
REQ-029 On rst, head, tail, count SHALL clear to 0 on the next edge: empty=1, full=0, two_avail=0, count=0.
REQ-030 rst SHALL take priority over we/re in the same cycle; a write presented during rst SHALL not be accepted.
REQ-031 RAM contents SHALL NOT be reset; reset mid-operation discards all entries.

Verification
REQ-032 Reset then we=1 with din=A,B,C on 3 cycles, re=0 -> count=3, dout0=A, dout1=B, two_avail=1.
REQ-033 With A,B,C queued, re=2'b11 one cycle -> count=1, dout0=C, two_avail=0; re=2'b11 next cycle -> rejected, count=1, assertion fires.
REQ-034 DEPTH=4: write 4 entries -> full=1; 5th we -> ignored; re=2'b01 && we same cycle while full -> count stays 3 after pop only, write dropped.
REQ-035 Wrap: fill/drain repeatedly so head crosses DEPTH-1 with re=2'b11 at head=DEPTH-1 -> dout0=ram[DEPTH-1], dout1=ram[0] popped in order.
REQ-036 Empty FIFO, we=1 din=X and re=2'b01 same cycle -> read rejected, count=1, dout0=X next cycle.
REQ-037 Random we/re (legal-only) for 10k cycles vs queue model -> dout0/dout1, count, flags match every cycle; rst asserted mid-run -> count=0, empty=1 next cycle.
